// File: rtl/boxcar_trig_pkg.sv
// Shared definitions for the boxcar integrator/trigger: default widths and
// the trigger FSM state encoding.
package boxcar_trig_pkg;

    localparam int DEF_NBITS_DATA = 42;
    localparam int DEF_NBITS_ADDR = 9;
    localparam int DEF_NBITS_HOLD = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIGH  = 2'd2,
        ST_HOLD  = 2'd3
    } trig_state_t;

endpackage

// File: rtl/boxcar_acc.sv
// Running window sum plus saturating fill counter; sum_next exposes the
// value the sum takes on the coming valid so the trigger can compare early.
module boxcar_acc
    import boxcar_trig_pkg::*;
#(
    parameter int P_NBITS_DATA = DEF_NBITS_DATA,
    parameter int P_NBITS_ADDR = DEF_NBITS_ADDR,
    parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic                    flush,
    input  logic [P_NBITS_DATA-1:0] qo,
    input  logic [P_NBITS_DATA-1:0] qn,
    input  logic [P_NBITS_ADDR-1:0] n,
    output logic [P_NBITS_SUM-1:0]  sum,
    output logic [P_NBITS_SUM-1:0]  sum_next,
    output logic [P_NBITS_ADDR-1:0] fill,
    output logic                    primed
);

    logic [P_NBITS_ADDR-1:0] fill_next;

    // Next-state sum (modulo 2^P_NBITS_SUM) and saturating fill count.
    always_comb begin
        sum_next = sum + P_NBITS_SUM'(qo) - P_NBITS_SUM'(qn);
        if (fill >= n) begin
            fill_next = n;
        end else begin
            fill_next = fill + P_NBITS_ADDR'(1);
        end
    end

    // Window state registers; flush outranks valid, reset outranks both.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum    <= '0;
            fill   <= '0;
            primed <= 1'b0;
        end else if (flush) begin
            sum    <= '0;
            fill   <= '0;
            primed <= 1'b0;
        end else if (valid) begin
            sum    <= sum_next;
            fill   <= fill_next;
            primed <= (n != '0) && (fill_next == n);
        end
    end

endmodule

// File: rtl/boxcar_trig.sv
// Boxcar integrator with threshold trigger and programmable re-arm holdoff,
// fed by ram_delay (newest sample qo, sample leaving the window qn).
module boxcar_trig
    import boxcar_trig_pkg::*;
#(
    parameter int P_NBITS_DATA = DEF_NBITS_DATA,
    parameter int P_NBITS_ADDR = DEF_NBITS_ADDR,
    parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR,
    parameter int P_NBITS_HOLD = DEF_NBITS_HOLD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [P_NBITS_DATA-1:0] qo,
    input  logic [P_NBITS_DATA-1:0] qn,
    input  logic [P_NBITS_ADDR-1:0] n,
    input  logic                    flush,
    input  logic [P_NBITS_SUM-1:0]  thresh,
    input  logic [P_NBITS_HOLD-1:0] holdoff,
    output logic [P_NBITS_SUM-1:0]  sum,
    output logic                    sum_valid,
    output logic                    primed,
    output logic                    trig
);

    logic [P_NBITS_SUM-1:0]  sum_next;
    logic [P_NBITS_ADDR-1:0] fill;
    logic [P_NBITS_HOLD-1:0] hold_cnt;
    trig_state_t             state;
    logic                    evaluate;
    logic                    above;

    boxcar_acc #(
        .P_NBITS_DATA (P_NBITS_DATA),
        .P_NBITS_ADDR (P_NBITS_ADDR),
        .P_NBITS_SUM  (P_NBITS_SUM)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .flush    (flush),
        .qo       (qo),
        .qn       (qn),
        .n        (n),
        .sum      (sum),
        .sum_next (sum_next),
        .fill     (fill),
        .primed   (primed)
    );

    // A sample is evaluated when its post-update fill equals n; since fill
    // never exceeds n, that is fill already at n or one short of it.
    always_comb begin
        evaluate = valid && !flush && (n != '0) &&
                   ((fill == n) || ((fill + P_NBITS_ADDR'(1)) == n));
        above    = (sum_next >= thresh);
    end

    // Trigger FSM, holdoff counter and the registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            sum_valid <= 1'b0;
            trig      <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            sum_valid <= 1'b0;
            trig      <= 1'b0;
        end else begin
            sum_valid <= valid;
            trig      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (evaluate) begin
                        if (above) begin
                            trig  <= 1'b1;
                            state <= ST_HIGH;
                        end else begin
                            state <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (evaluate && above) begin
                        trig  <= 1'b1;
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (evaluate && !above) begin
                        if (holdoff == '0) begin
                            state <= ST_ARMED;
                        end else begin
                            hold_cnt <= holdoff;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Counts real clocks, not samples; the last count re-arms.
                    if (hold_cnt <= P_NBITS_HOLD'(1)) begin
                        hold_cnt <= '0;
                        state    <= ST_ARMED;
                    end else begin
                        hold_cnt <= hold_cnt - P_NBITS_HOLD'(1);
                    end
                end
                default: begin
                    hold_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boxcar_trig.sv
// Directed bench for boxcar_trig: models the ram_delay line and the window
// sum, and checks strobes against hand-computed trigger points.
module tb_boxcar_trig;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [41:0] qo;
    logic [41:0] qn;
    logic [8:0]  n;
    logic        flush;
    logic [50:0] thresh;
    logic [15:0] holdoff;
    logic [50:0] sum;
    logic        sum_valid;
    logic        primed;
    logic        trig;

    int          n_checks;
    int          n_fail;
    logic [50:0] sum_m;
    int          fill_m;
    logic [41:0] line[$];
    logic [41:0] hvals[12];

    boxcar_trig dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .qo        (qo),
        .qn        (qn),
        .n         (n),
        .flush     (flush),
        .thresh    (thresh),
        .holdoff   (holdoff),
        .sum       (sum),
        .sum_valid (sum_valid),
        .primed    (primed),
        .trig      (trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One write of ram_delay: newest sample d, oldest leaves the window.
    task automatic push(input logic [41:0] d, input logic exp_trig);
        logic [41:0] old;
        @(negedge clk);
        if (line.size() > 0) begin
            old = line.pop_front();
            line.push_back(d);
        end else begin
            old = 42'd0;
        end
        flush = 1'b0;
        valid = 1'b1;
        qo    = d;
        qn    = old;
        sum_m = sum_m + {9'd0, d} - {9'd0, old};
        if (fill_m != int'(n)) fill_m++;
        @(posedge clk);
        #1;
        check_eq("sum_valid", {63'd0, sum_valid}, 64'd1);
        check_eq("sum", {13'd0, sum}, {13'd0, sum_m});
        check_eq("trig", {63'd0, trig}, {63'd0, exp_trig});
        check_eq("primed", {63'd0, primed}, {63'd0, (n != 9'd0) && (fill_m == int'(n))});
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_sum_valid", {63'd0, sum_valid}, 64'd0);
        check_eq("idle_trig", {63'd0, trig}, 64'd0);
    endtask

    // Flush with junk valid writes; upstream zero-fills the line meanwhile.
    task automatic do_flush(input logic [8:0] new_n);
        int cycles;
        cycles = (new_n == 9'd0) ? 1 : int'(new_n);
        @(negedge clk);
        flush = 1'b1;
        valid = 1'b1;
        qo    = 42'h155;
        qn    = 42'h0aa;
        n     = new_n;
        @(posedge clk);
        #1;
        check_eq("flush_sum_valid", {63'd0, sum_valid}, 64'd0);
        check_eq("flush_sum", {13'd0, sum}, 64'd0);
        check_eq("flush_primed", {63'd0, primed}, 64'd0);
        check_eq("flush_trig", {63'd0, trig}, 64'd0);
        for (int i = 1; i < cycles; i++) @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        line.delete();
        for (int i = 0; i < int'(new_n); i++) line.push_back(42'd0);
        sum_m  = 51'd0;
        fill_m = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sum_m    = 51'd0;
        fill_m   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        valid    = 1'b0;
        qo       = 42'd0;
        qn       = 42'd0;
        n        = 9'd16;
        thresh   = 51'd0;
        holdoff  = 16'd0;
        hvals    = '{42'd0, 42'd0, 42'd0, 42'd0, 42'd0, 42'd0, 42'd0,
                     42'd40, 42'd0, 42'd0, 42'd0, 42'd0};

        // Reset with random inputs
        repeat (3) begin
            @(negedge clk);
            valid = 1'($urandom());
            flush = 1'($urandom());
            qo    = 42'({$urandom(), $urandom()});
            qn    = 42'({$urandom(), $urandom()});
            @(posedge clk);
            #1;
            check_eq("rst_sum_valid", {63'd0, sum_valid}, 64'd0);
        end
        check_eq("rst_sum", {13'd0, sum}, 64'd0);
        check_eq("rst_primed", {63'd0, primed}, 64'd0);
        check_eq("rst_trig", {63'd0, trig}, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        flush = 1'b0;

        // Window primed with zeros, then 5s: trigger at the 10th five (sum 50)
        thresh  = 51'd50;
        holdoff = 16'd0;
        do_flush(9'd16);
        for (int i = 0; i < 16; i++) push(42'd0, 1'b0);
        for (int i = 0; i < 20; i++) push(42'd5, i == 9);
        check_eq("fill_sum_80", {13'd0, sum}, 64'd80);
        idle_cycle();

        // Holdoff 4: trigger on priming, drop to 45, HOLD masks sum 80,
        // first sample after four HOLD cycles (sum 60) fires
        holdoff = 16'd4;
        do_flush(9'd16);
        for (int i = 0; i < 16; i++) push(42'd5, i == 15);
        for (int i = 0; i < 12; i++) push(hvals[i], i == 11);
        check_eq("hold_sum_60", {13'd0, sum}, 64'd60);
        idle_cycle();

        // Holdoff 0: straight back to ARMED, the 40 sample fires (sum 80)
        holdoff = 16'd0;
        do_flush(9'd16);
        for (int i = 0; i < 16; i++) push(42'd5, i == 15);
        for (int i = 0; i < 12; i++) push(hvals[i], i == 7);

        // Flush mid-stream while HIGH and primed; thresh 80 fires on priming
        thresh = 51'd80;
        do_flush(9'd16);
        for (int i = 0; i < 20; i++) push(42'd5, i == 15);
        idle_cycle();

        // Width corner: 16 all-ones samples, then drain with zeros
        thresh = {51{1'b1}};
        do_flush(9'd16);
        for (int i = 0; i < 16; i++) push({42{1'b1}}, 1'b0);
        check_eq("ones_sum", {13'd0, sum}, 64'h0000_3FFF_FFFF_FFF0);
        for (int i = 0; i < 16; i++) push(42'd0, 1'b0);
        check_eq("drain_sum", {13'd0, sum}, 64'd0);

        // n = 0: never primed, never triggers even with thresh 0
        thresh = 51'd0;
        do_flush(9'd0);
        for (int i = 0; i < 4; i++) push(42'd5, 1'b0);

        // Reset mid-operation
        do_flush(9'd4);
        for (int i = 0; i < 5; i++) push(42'd7, i == 3);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b1;
        qo    = 42'd9;
        @(posedge clk);
        #1;
        check_eq("mid_rst_sum", {13'd0, sum}, 64'd0);
        check_eq("mid_rst_primed", {63'd0, primed}, 64'd0);
        check_eq("mid_rst_sum_valid", {63'd0, sum_valid}, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
